// File: rtl/mips_pkg.sv
// Shared definitions for the memory arbiter slice.
//
// Contents:
//   arb_state_t      arbiter FSM state encoding
//   TIMEOUT_DEFAULT  default wait limit before an access is aborted
//   BE_*             mem_be lane patterns (bit 1 = bits 15:8, bit 0 = bits 7:0)
//   be_for_access()  byte-enable pattern for a data access
package mips_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_DATA   = 2'd2,
        ST_HALTED = 2'd3
    } arb_state_t;

    localparam int TIMEOUT_DEFAULT = 15;

    // Big-endian lanes: the even byte address lives in bits 15:8.
    localparam logic [1:0] BE_WORD = 2'b11;
    localparam logic [1:0] BE_HI   = 2'b10;
    localparam logic [1:0] BE_LO   = 2'b01;

    function automatic logic [1:0] be_for_access(input logic word_en, input logic addr_lsb);
        if (word_en) begin
            return BE_WORD;
        end
        return addr_lsb ? BE_LO : BE_HI;
    endfunction

endpackage

// File: rtl/mem_byte_lane.sv
// Byte-lane formatting between the data requester and the 16-bit memory.
// Purely combinational.
//
// Ports:
//   word_en    in   1 = 16-bit access, 0 = byte access
//   addr_lsb   in   byte address bit 0 (selects lane for byte accesses)
//   wdata_in   in   requester store data (byte stores use [7:0])
//   be         out  byte enables for the access being granted
//   wdata_out  out  store data replicated onto the enabled lane(s)
//   rd_be      in   byte enables of the access in flight
//   mem_rdata  in   raw memory read data
//   rdata_out  out  load data: word as-is, byte sign-extended to 16 bits
module mem_byte_lane
    import mips_pkg::*;
(
    input  logic        word_en,
    input  logic        addr_lsb,
    input  logic [15:0] wdata_in,
    output logic [1:0]  be,
    output logic [15:0] wdata_out,
    input  logic [1:0]  rd_be,
    input  logic [15:0] mem_rdata,
    output logic [15:0] rdata_out
);

    always_comb begin
        be        = be_for_access(word_en, addr_lsb);
        // Byte stores drive the same byte on both lanes; be picks the real one.
        wdata_out = word_en ? wdata_in : {wdata_in[7:0], wdata_in[7:0]};
    end

    // The lane in use is recovered from the registered byte enables, so the
    // requester's address/size inputs do not need to stay stable for loads.
    always_comb begin
        rdata_out = mem_rdata;
        unique case (rd_be)
            BE_HI:   rdata_out = {{8{mem_rdata[15]}}, mem_rdata[15:8]};
            BE_LO:   rdata_out = {{8{mem_rdata[7]}}, mem_rdata[7:0]};
            default: rdata_out = mem_rdata;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and data access.
// Data requests win over fetches; a halt request stops further fetching once
// the in-flight access has completed, while data requests are still served.
// An access that waits TIMEOUT cycles without mem_ack is completed with zero
// read data and flags the sticky bus_err.
//
// Handshake: a requester raises *_req with its address/data and holds them
// until the matching *_ack pulse; *_ack is high for exactly the cycle in which
// memory acknowledges (or the access times out), and the requester drops its
// request the following cycle. mem_req stays high from the cycle after the
// grant until mem_ack; mem_* fields are registered at grant and stay stable.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   if_req/if_addr              fetch request and address
//   if_ack/if_rdata             fetch completion and instruction
//   d_req/d_we/d_word_en        data request, store flag, word/byte size
//   d_addr/d_wdata              data address and store data
//   d_ack/d_rdata               data completion and load data
//   halt                        stop fetching (sticky until reset)
//   mem_req/mem_we/mem_be       memory request, write, byte enables
//   mem_addr/mem_wdata          memory address and write data
//   mem_rdata/mem_ack           memory read data and completion
//   stall                       a requester is waiting
//   bus_err                     sticky timeout flag
//   halted                      arbiter is in the HALTED state
module mem_arbiter
    import mips_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    output logic        if_ack,
    output logic [15:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic        d_word_en,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic        d_ack,
    output logic [15:0] d_rdata,
    input  logic        halt,
    output logic        mem_req,
    output logic        mem_we,
    output logic [1:0]  mem_be,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    output logic        stall,
    output logic        bus_err,
    output logic        halted
);

    localparam int CW = ($clog2(TIMEOUT + 1) > 4) ? $clog2(TIMEOUT + 1) : 4;
    localparam logic [CW-1:0] TIMEOUT_CNT = CW'(TIMEOUT);

    arb_state_t    state_q, state_d;
    logic          halt_pend_q, halt_pend_d;
    logic          bus_err_q, bus_err_d;
    logic [CW-1:0] wait_cnt_q, wait_cnt_d;
    logic [15:0]   addr_q, addr_d;
    logic          we_q, we_d;
    logic [1:0]    be_q, be_d;
    logic [15:0]   wdata_q, wdata_d;

    logic [1:0]    grant_be;
    logic [15:0]   grant_wdata;
    logic [15:0]   load_rdata;
    logic          in_access;
    logic          timeout_hit;
    logic          access_done;
    logic          halt_any;

    mem_byte_lane u_byte_lane (
        .word_en   (d_word_en),
        .addr_lsb  (d_addr[0]),
        .wdata_in  (d_wdata),
        .be        (grant_be),
        .wdata_out (grant_wdata),
        .rd_be     (be_q),
        .mem_rdata (mem_rdata),
        .rdata_out (load_rdata)
    );

    assign in_access   = (state_q == ST_FETCH) || (state_q == ST_DATA);
    // A real mem_ack in the limit cycle still wins over the abort.
    assign timeout_hit = in_access && !mem_ack && (wait_cnt_q == TIMEOUT_CNT);
    assign access_done = in_access && (mem_ack || timeout_hit);
    // A halt arriving in the same cycle as an IDLE decision already counts.
    assign halt_any    = halt_pend_q || halt;

    always_comb begin
        state_d     = state_q;
        halt_pend_d = halt_any;
        bus_err_d   = bus_err_q || timeout_hit;
        wait_cnt_d  = wait_cnt_q;
        addr_d      = addr_q;
        we_d        = we_q;
        be_d        = be_q;
        wdata_d     = wdata_q;

        unique case (state_q)
            ST_IDLE, ST_HALTED: begin
                if (d_req) begin
                    state_d    = ST_DATA;
                    wait_cnt_d = '0;
                    addr_d     = d_addr;
                    we_d       = d_we;
                    be_d       = grant_be;
                    wdata_d    = grant_wdata;
                end else if ((state_q == ST_IDLE) && if_req && !halt_any) begin
                    state_d    = ST_FETCH;
                    wait_cnt_d = '0;
                    addr_d     = if_addr;
                    we_d       = 1'b0;
                    be_d       = BE_WORD;
                    wdata_d    = '0;
                end else if (halt_any) begin
                    state_d = ST_HALTED;
                end
            end
            ST_FETCH, ST_DATA: begin
                if (access_done) begin
                    // Leaving through IDLE lets a halted arbiter fall back to HALTED.
                    state_d = ST_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            halt_pend_q <= 1'b0;
            bus_err_q   <= 1'b0;
            wait_cnt_q  <= '0;
            addr_q      <= '0;
            we_q        <= 1'b0;
            be_q        <= '0;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            halt_pend_q <= halt_pend_d;
            bus_err_q   <= bus_err_d;
            wait_cnt_q  <= wait_cnt_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
        end
    end

    assign mem_req   = in_access;
    assign mem_we    = in_access && we_q;
    assign mem_be    = be_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    assign if_ack    = (state_q == ST_FETCH) && access_done;
    assign d_ack     = (state_q == ST_DATA) && access_done;
    // Timed-out accesses return zero because mem_ack is low in that cycle.
    assign if_rdata  = ((state_q == ST_FETCH) && mem_ack) ? mem_rdata : '0;
    assign d_rdata   = ((state_q == ST_DATA) && mem_ack) ? load_rdata : '0;

    assign stall     = (if_req && !if_ack) || (d_req && !d_ack);
    assign bus_err   = bus_err_q;
    assign halted    = (state_q == ST_HALTED);

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_req, d_req, d_we, d_word_en, halt, mem_ack;
    logic [15:0] if_addr, d_addr, d_wdata, mem_rdata;
    logic        if_ack, d_ack, mem_req, mem_we, stall, bus_err, halted;
    logic [15:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    logic [1:0]  mem_be;

    int chk_cnt = 0;
    int pass_cnt = 0;
    logic [15:0] exp_q[$];

    typedef struct {
        int          lat;
        logic [15:0] addr;
        logic        we;
        logic [1:0]  be;
        logic [15:0] wdata;
        logic        stall;
        logic        ack;
        logic        other_ack;
        logic [15:0] rdata;
    } obs_t;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    mem_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_word_en(d_word_en), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata),
        .halt(halt),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .stall(stall), .bus_err(bus_err), .halted(halted)
    );

    // ---------------- reference model ----------------
    // Expected behaviour from the byte-lane rules: even address = high byte.
    function automatic logic [1:0] model_be(input logic word, input logic [15:0] addr);
        if (word) return 2'd3;
        return (addr % 2 == 1) ? 2'd1 : 2'd2;
    endfunction

    function automatic logic [15:0] model_wdata(input logic word, input logic [15:0] d);
        if (word) return d;
        return 16'((d % 256) * 257);
    endfunction

    function automatic logic [15:0] model_load(input logic word, input logic [15:0] addr,
                                               input logic [15:0] r);
        int b;
        if (word) return r;
        b = (addr % 2 == 1) ? (r % 256) : (r / 256);
        if (b >= 128) b = b - 256;
        return 16'(b);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_word_en = 0;
        d_addr = 0; d_wdata = 0; halt = 0; mem_rdata = 0; mem_ack = 0;
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        reset = 1;
        idle_inputs();
        repeat (cycles) @(negedge clk);
        reset = 0;
    endtask

    // Bounded wait for mem_req; lat = cycles after the request, 0 if never seen.
    task automatic wait_grant(output int lat);
        lat = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk); #1;
            if (mem_req) begin
                lat = i;
                break;
            end
        end
    endtask

    // One complete access; starts and ends on a negedge.
    task automatic run_access(input bit is_data, input logic we, input logic word,
                              input logic [15:0] addr, input logic [15:0] wdata,
                              input logic [15:0] rdata, input int delay, output obs_t o);
        if (is_data) begin
            d_req = 1; d_we = we; d_word_en = word; d_addr = addr; d_wdata = wdata;
        end else begin
            if_req = 1; if_addr = addr;
        end
        wait_grant(o.lat);
        o.addr = mem_addr; o.we = mem_we; o.be = mem_be; o.wdata = mem_wdata;
        o.stall = stall;
        repeat (delay) @(negedge clk);
        mem_rdata = rdata;
        mem_ack = 1;
        #1;
        o.ack       = is_data ? d_ack : if_ack;
        o.other_ack = is_data ? if_ack : d_ack;
        o.rdata     = is_data ? d_rdata : if_rdata;
        @(negedge clk);
        d_req = 0; if_req = 0; mem_ack = 0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int lat;
        bit bad;
        reset = 1;
        idle_inputs();
        repeat (3) @(negedge clk);
        #1;
        chk_cnt++; if (mem_req !== 1'b0) $display("FAIL reset_mem_req: got %b want 0", mem_req); else pass_cnt++;
        chk_cnt++; if (halted !== 1'b0 || bus_err !== 1'b0 || stall !== 1'b0)
            $display("FAIL reset_flags: halted=%b bus_err=%b stall=%b want 000", halted, bus_err, stall); else pass_cnt++;
        chk_cnt++; if ({mem_addr, mem_wdata, mem_be, mem_we} !== 35'd0)
            $display("FAIL reset_mem_fields: addr=%h wdata=%h be=%b we=%b want all 0", mem_addr, mem_wdata, mem_be, mem_we); else pass_cnt++;
        @(negedge clk);
        reset = 0;

        // Reset in the middle of a fetch abandons it; later mem_ack is ignored.
        if_req = 1; if_addr = 16'h0100;
        wait_grant(lat);
        chk_cnt++; if (lat !== 1) $display("FAIL abort_grant_latency: got %0d want 1", lat); else pass_cnt++;
        reset = 1; if_req = 0;
        @(negedge clk);
        reset = 0; mem_ack = 1; mem_rdata = 16'h5555;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (if_ack || d_ack || mem_req) bad = 1;
            @(negedge clk);
        end
        mem_ack = 0;
        chk_cnt++; if (bad !== 1'b0) $display("FAIL abort_no_ack: got ack/mem_req after reset want none"); else pass_cnt++;
    endtask

    task automatic test_word_load();
        obs_t o;
        run_access(1, 0, 1, 16'h0010, 16'h0000, 16'h1234, 2, o);
        chk_cnt++; if (o.lat !== 1) $display("FAIL word_load_latency: got %0d want 1", o.lat); else pass_cnt++;
        chk_cnt++; if (o.addr !== 16'h0010 || o.be !== 2'b11 || o.we !== 1'b0)
            $display("FAIL word_load_bus: addr=%h be=%b we=%b want 0010 11 0", o.addr, o.be, o.we); else pass_cnt++;
        chk_cnt++; if (o.stall !== 1'b1) $display("FAIL word_load_stall: got %b want 1", o.stall); else pass_cnt++;
        chk_cnt++; if (o.ack !== 1'b1 || o.other_ack !== 1'b0 || o.rdata !== 16'h1234)
            $display("FAIL word_load_ack: ack=%b if_ack=%b rdata=%h want 1 0 1234", o.ack, o.other_ack, o.rdata); else pass_cnt++;
    endtask

    task automatic test_priority();
        int lat;
        bit extra;
        if_req = 1; if_addr = 16'h0004;
        d_req = 1; d_we = 0; d_word_en = 1; d_addr = 16'h0020;
        wait_grant(lat);
        chk_cnt++; if (lat !== 1 || mem_addr !== 16'h0020)
            $display("FAIL prio_first: lat=%0d addr=%h want 1 0020", lat, mem_addr); else pass_cnt++;
        chk_cnt++; if (stall !== 1'b1) $display("FAIL prio_stall: got %b want 1", stall); else pass_cnt++;
        mem_rdata = 16'h7777; mem_ack = 1; #1;
        chk_cnt++; if (d_ack !== 1'b1 || if_ack !== 1'b0 || d_rdata !== 16'h7777)
            $display("FAIL prio_d_ack: d_ack=%b if_ack=%b d_rdata=%h want 1 0 7777", d_ack, if_ack, d_rdata); else pass_cnt++;
        @(negedge clk);
        d_req = 0; mem_ack = 0;
        wait_grant(lat);
        chk_cnt++; if (lat !== 1 || mem_addr !== 16'h0004 || mem_we !== 1'b0)
            $display("FAIL prio_second: lat=%0d addr=%h we=%b want 1 0004 0", lat, mem_addr, mem_we); else pass_cnt++;
        mem_rdata = 16'h8421; mem_ack = 1; #1;
        chk_cnt++; if (if_ack !== 1'b1 || d_ack !== 1'b0 || if_rdata !== 16'h8421)
            $display("FAIL prio_if_ack: if_ack=%b d_ack=%b if_rdata=%h want 1 0 8421", if_ack, d_ack, if_rdata); else pass_cnt++;
        @(negedge clk);
        if_req = 0; mem_ack = 0;
        extra = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (if_ack || d_ack || mem_req) extra = 1;
            @(negedge clk);
        end
        chk_cnt++; if (extra !== 1'b0) $display("FAIL prio_single_ack: extra activity seen want none"); else pass_cnt++;
    endtask

    task automatic test_byte_load();
        obs_t o;
        run_access(1, 0, 0, 16'h0021, 16'h0000, 16'h12F0, 1, o);
        chk_cnt++; if (o.be !== 2'b01 || o.ack !== 1'b1 || o.rdata !== 16'hFFF0)
            $display("FAIL byte_load_odd: be=%b ack=%b rdata=%h want 01 1 fff0", o.be, o.ack, o.rdata); else pass_cnt++;
        run_access(1, 0, 0, 16'h0020, 16'h0000, 16'h12F0, 0, o);
        chk_cnt++; if (o.be !== 2'b10 || o.ack !== 1'b1 || o.rdata !== 16'h0012)
            $display("FAIL byte_load_even: be=%b ack=%b rdata=%h want 10 1 0012", o.be, o.ack, o.rdata); else pass_cnt++;
    endtask

    task automatic test_byte_store();
        obs_t o;
        run_access(1, 1, 0, 16'h0020, 16'h00AB, 16'h0000, 0, o);
        chk_cnt++; if (o.we !== 1'b1 || o.be !== 2'b10 || o.wdata !== 16'hABAB || o.addr !== 16'h0020)
            $display("FAIL byte_store: we=%b be=%b wdata=%h addr=%h want 1 10 abab 0020", o.we, o.be, o.wdata, o.addr); else pass_cnt++;
        chk_cnt++; if (o.ack !== 1'b1) $display("FAIL byte_store_ack: got %b want 1", o.ack); else pass_cnt++;
    endtask

    task automatic test_random();
        obs_t o;
        bit is_data;
        logic we, word;
        logic [15:0] addr, wdata, rdata, exp;
        for (int n = 0; n < 40; n++) begin
            is_data = 1'($urandom_range(0, 1));
            we      = is_data ? 1'($urandom_range(0, 1)) : 1'b0;
            word    = 1'($urandom_range(0, 1));
            addr    = 16'($urandom);
            wdata   = 16'($urandom);
            rdata   = 16'($urandom);
            if (!we) exp_q.push_back(is_data ? model_load(word, addr, rdata) : rdata);
            run_access(is_data, we, word, addr, wdata, rdata, $urandom_range(0, 3), o);
            chk_cnt++; if (o.lat !== 1 || o.ack !== 1'b1 || o.other_ack !== 1'b0)
                $display("FAIL rnd_handshake[%0d]: lat=%0d ack=%b other=%b want 1 1 0", n, o.lat, o.ack, o.other_ack); else pass_cnt++;
            chk_cnt++; if (o.addr !== addr || o.we !== we)
                $display("FAIL rnd_addr_we[%0d]: addr=%h we=%b want %h %b", n, o.addr, o.we, addr, we); else pass_cnt++;
            if (is_data) begin
                chk_cnt++; if (o.be !== model_be(word, addr))
                    $display("FAIL rnd_be[%0d]: got %b want %b", n, o.be, model_be(word, addr)); else pass_cnt++;
            end
            if (we) begin
                chk_cnt++; if (o.wdata !== model_wdata(word, wdata))
                    $display("FAIL rnd_wdata[%0d]: got %h want %h", n, o.wdata, model_wdata(word, wdata)); else pass_cnt++;
            end else begin
                exp = exp_q.pop_front();
                chk_cnt++; if (o.rdata !== exp)
                    $display("FAIL rnd_rdata[%0d]: got %h want %h", n, o.rdata, exp); else pass_cnt++;
            end
        end
    endtask

    task automatic test_back_to_back();
        obs_t o;
        run_access(0, 0, 1, 16'h0400, 16'h0000, 16'h1111, 0, o);
        chk_cnt++; if (o.lat !== 1 || o.ack !== 1'b1) $display("FAIL b2b_fetch1: lat=%0d ack=%b want 1 1", o.lat, o.ack); else pass_cnt++;
        run_access(1, 1, 1, 16'h0500, 16'hCAFE, 16'h0000, 0, o);
        chk_cnt++; if (o.lat !== 1 || o.ack !== 1'b1 || o.wdata !== 16'hCAFE || o.be !== 2'b11)
            $display("FAIL b2b_store: lat=%0d ack=%b wdata=%h be=%b want 1 1 cafe 11", o.lat, o.ack, o.wdata, o.be); else pass_cnt++;
        run_access(0, 0, 1, 16'h0402, 16'h0000, 16'h2222, 0, o);
        chk_cnt++; if (o.lat !== 1 || o.rdata !== 16'h2222) $display("FAIL b2b_fetch2: lat=%0d rdata=%h want 1 2222", o.lat, o.rdata); else pass_cnt++;
        #1;
        chk_cnt++; if (stall !== 1'b0) $display("FAIL idle_stall: got %b want 0", stall); else pass_cnt++;
    endtask

    task automatic test_timeout();
        int lat, waited;
        bit got;
        obs_t o;
        if_req = 1; if_addr = 16'h0042; mem_rdata = 16'hBEEF; mem_ack = 0;
        wait_grant(lat);
        waited = 0; got = 0;
        for (int i = 0; i < 40; i++) begin
            if (if_ack) begin
                got = 1;
                break;
            end
            waited++;
            @(negedge clk); #1;
        end
        chk_cnt++; if (got !== 1'b1 || waited !== TO)
            $display("FAIL timeout_ack: acked=%b after %0d silent cycles want 1 after %0d", got, waited, TO); else pass_cnt++;
        chk_cnt++; if (if_rdata !== 16'h0000) $display("FAIL timeout_rdata: got %h want 0000", if_rdata); else pass_cnt++;
        @(negedge clk);
        if_req = 0;
        #1;
        chk_cnt++; if (bus_err !== 1'b1 || mem_req !== 1'b0)
            $display("FAIL timeout_bus_err: bus_err=%b mem_req=%b want 1 0", bus_err, mem_req); else pass_cnt++;
        @(negedge clk);
        run_access(1, 0, 1, 16'h0060, 16'h0000, 16'h0F0F, 1, o);
        #1;
        chk_cnt++; if (bus_err !== 1'b1 || o.rdata !== 16'h0F0F)
            $display("FAIL bus_err_sticky: bus_err=%b rdata=%h want 1 0f0f", bus_err, o.rdata); else pass_cnt++;
        do_reset(2);
        #1;
        chk_cnt++; if (bus_err !== 1'b0) $display("FAIL bus_err_reset: got %b want 0", bus_err); else pass_cnt++;
    endtask

    task automatic test_halt();
        int lat;
        bit found, bad;
        obs_t o;
        @(negedge clk);
        if_req = 1; if_addr = 16'h0200;
        wait_grant(lat);
        halt = 1;
        @(negedge clk);
        halt = 0;
        mem_rdata = 16'h3C3C; mem_ack = 1; #1;
        chk_cnt++; if (if_ack !== 1'b1 || if_rdata !== 16'h3C3C)
            $display("FAIL halt_inflight_ack: if_ack=%b rdata=%h want 1 3c3c", if_ack, if_rdata); else pass_cnt++;
        @(negedge clk);
        if_req = 0; mem_ack = 0;
        #1;
        found = 0;
        for (int i = 0; i < 6; i++) begin
            if (halted) begin
                found = 1;
                break;
            end
            @(negedge clk); #1;
        end
        chk_cnt++; if (found !== 1'b1) $display("FAIL halt_enter: halted=%b want 1", halted); else pass_cnt++;

        if_req = 1; if_addr = 16'h0300;
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            mem_ack = 1'($urandom_range(0, 1)); mem_rdata = 16'($urandom);
            #1;
            if (if_ack || mem_req || !halted) bad = 1;
            @(negedge clk);
        end
        #1;
        chk_cnt++; if (bad !== 1'b0 || stall !== 1'b1)
            $display("FAIL halt_no_fetch: fetch activity=%b stall=%b want 0 1", bad, stall); else pass_cnt++;
        @(negedge clk);
        if_req = 0; mem_ack = 0;

        run_access(1, 0, 0, 16'h0031, 16'h0000, 16'h0080, 1, o);
        chk_cnt++; if (o.lat !== 1 || o.ack !== 1'b1 || o.rdata !== 16'hFF80 || o.be !== 2'b01)
            $display("FAIL halt_data_served: lat=%0d ack=%b rdata=%h be=%b want 1 1 ff80 01", o.lat, o.ack, o.rdata, o.be); else pass_cnt++;
        #1;
        found = 0;
        for (int i = 0; i < 6; i++) begin
            if (halted) begin
                found = 1;
                break;
            end
            @(negedge clk); #1;
        end
        chk_cnt++; if (found !== 1'b1) $display("FAIL halt_return: halted=%b want 1", halted); else pass_cnt++;

        do_reset(2);
        #1;
        chk_cnt++; if (halted !== 1'b0) $display("FAIL halt_reset: halted=%b want 0", halted); else pass_cnt++;
        @(negedge clk);
        run_access(0, 0, 1, 16'h0300, 16'h0000, 16'h4D4D, 0, o);
        chk_cnt++; if (o.lat !== 1 || o.ack !== 1'b1 || o.rdata !== 16'h4D4D)
            $display("FAIL fetch_after_reset: lat=%0d ack=%b rdata=%h want 1 1 4d4d", o.lat, o.ack, o.rdata); else pass_cnt++;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        idle_inputs();
        test_reset();
        test_word_load();
        test_priority();
        test_byte_load();
        test_byte_store();
        test_random();
        test_back_to_back();
        test_timeout();
        test_halt();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
